// File: rtl/bp_group_decoder.sv
// bp_group_decoder: bit-serial decoder for the ECG BP-mode packed bitstream.
// A group is a 4-bit width header (MSB first) followed by four samples coded
// at that width. Sign-magnitude samples (ecgidx 0..2) carry a sign bit before
// the magnitude. Two's complement samples (ecgidx 3) carry only W bits.
// Decoded samples are handed downstream one per handshake, tagged 0..3.
module bp_group_decoder #(
    parameter int J = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   ecgidx,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic         bit_ready,
    output logic [J-1:0] sample_out,
    output logic [1:0]   sample_idx,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic         hdr_err,
    output logic         group_done
);

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_SIGN = 2'd1,
        ST_MAG  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Widest header value that still fits in a J-bit sample.
    localparam logic [3:0] MAX_WIDTH = 4'(J);
    localparam logic [J:0] ZERO_WIDE = '0;

    state_t       state_q;
    logic [3:0]   hdrShift_q;
    logic [3:0]   width_q;
    logic [3:0]   bitCnt_q;
    logic         modeTc_q;
    logic         sign_q;
    logic [J-1:0] acc_q;
    logic [J-1:0] sampleOut_q;
    logic [1:0]   sampleIdx_q;
    logic         hdrErr_q;
    logic         groupDone_q;

    logic         bitFire;
    logic         sampleFire;
    logic [3:0]   hdrNext;
    logic [J-1:0] accNext;
    logic [J:0]   magWide;
    logic [J:0]   smWide;
    logic [J-1:0] smValue;
    logic [J-1:0] tcMask;
    logic [J-1:0] tcValue;

    // Handshakes, the next shift-register values and both candidate sample values.
    always_comb begin
        bit_ready    = (state_q != ST_OUT);
        sample_valid = (state_q == ST_OUT);
        bitFire      = bit_valid && bit_ready;
        sampleFire   = sample_valid && sample_ready;

        hdrNext = {hdrShift_q[2:0], bit_in};
        accNext = {acc_q[J-2:0], bit_in};

        // Negation is done one bit wider so a full-width magnitude of 2^(J-1)
        // lands on the most negative J-bit value after truncation.
        magWide = {1'b0, accNext};
        smWide  = sign_q ? (ZERO_WIDE - magWide) : magWide;
        smValue = smWide[J-1:0];

        // Ones above the coded width, used to sign-extend a W-bit value.
        tcMask  = {J{1'b1}} << width_q;
        tcValue = accNext[width_q - 4'd1] ? (accNext | tcMask) : accNext;
    end

    // Group decoding state machine with registered sample and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HDR;
            hdrShift_q  <= '0;
            width_q     <= '0;
            bitCnt_q    <= '0;
            modeTc_q    <= 1'b0;
            sign_q      <= 1'b0;
            acc_q       <= '0;
            sampleOut_q <= '0;
            sampleIdx_q <= '0;
            hdrErr_q    <= 1'b0;
            groupDone_q <= 1'b0;
        end else begin
            hdrErr_q    <= 1'b0;
            groupDone_q <= 1'b0;

            unique case (state_q)
                ST_HDR: begin
                    if (bitFire) begin
                        hdrShift_q <= hdrNext;
                        if (bitCnt_q == 4'd0) begin
                            modeTc_q <= (ecgidx == 2'd3);
                        end
                        if (bitCnt_q == 4'd3) begin
                            bitCnt_q    <= '0;
                            acc_q       <= '0;
                            sampleIdx_q <= '0;
                            if (hdrNext > MAX_WIDTH) begin
                                hdrErr_q <= 1'b1;
                            end else begin
                                width_q <= hdrNext;
                                if (hdrNext == 4'd0) begin
                                    sampleOut_q <= '0;
                                    state_q     <= ST_OUT;
                                end else if (modeTc_q) begin
                                    state_q <= ST_MAG;
                                end else begin
                                    state_q <= ST_SIGN;
                                end
                            end
                        end else begin
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end
                    end
                end

                ST_SIGN: begin
                    if (bitFire) begin
                        sign_q   <= bit_in;
                        acc_q    <= '0;
                        bitCnt_q <= '0;
                        state_q  <= ST_MAG;
                    end
                end

                ST_MAG: begin
                    if (bitFire) begin
                        acc_q <= accNext;
                        if (bitCnt_q == width_q - 4'd1) begin
                            bitCnt_q    <= '0;
                            sampleOut_q <= modeTc_q ? tcValue : smValue;
                            state_q     <= ST_OUT;
                        end else begin
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end
                    end
                end

                ST_OUT: begin
                    if (sampleFire) begin
                        if (sampleIdx_q == 2'd3) begin
                            groupDone_q <= 1'b1;
                            sampleIdx_q <= '0;
                            bitCnt_q    <= '0;
                            state_q     <= ST_HDR;
                        end else begin
                            sampleIdx_q <= sampleIdx_q + 2'd1;
                            acc_q       <= '0;
                            bitCnt_q    <= '0;
                            if (width_q == 4'd0) begin
                                sampleOut_q <= '0;
                            end else if (modeTc_q) begin
                                state_q <= ST_MAG;
                            end else begin
                                state_q <= ST_SIGN;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= ST_HDR;
                end
            endcase
        end
    end

    assign sample_out = sampleOut_q;
    assign sample_idx = sampleIdx_q;
    assign hdr_err    = hdrErr_q;
    assign group_done = groupDone_q;

endmodule

// File: tb/tb_bp_group_decoder.sv
// tb_bp_group_decoder: drives encoded groups into bp_group_decoder and checks
// the decoded samples, pulses and handshake rules against a queue-based model
// built from a behavioural encoder of sample values.
module tb_bp_group_decoder;

    localparam int J = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   ecgidx;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic [J-1:0] sample_out;
    logic [1:0]   sample_idx;
    logic         sample_valid;
    logic         sample_ready;
    logic         hdr_err;
    logic         group_done;

    bp_group_decoder #(.J(J)) dut (
        .clk          (clk),
        .rst          (rst),
        .ecgidx       (ecgidx),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .sample_out   (sample_out),
        .sample_idx   (sample_idx),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .hdr_err      (hdr_err),
        .group_done   (group_done)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    typedef struct {
        bit         b;
        logic [1:0] ecg;
        bit         illegalEnd;
        bit         validNext;
    } bitItem_t;

    typedef struct {
        logic [J-1:0] val;
        logic [1:0]   idx;
        bit           last;
    } sampleItem_t;

    bitItem_t    bitQ[$];
    sampleItem_t expQ[$];

    int nCompared   = 0;
    int nMismatched = 0;
    int bitsTaken   = 0;
    int doneCount   = 0;

    bit           hdrErrExp    = 1'b0;
    bit           groupDoneExp = 1'b0;
    bit           validExp     = 1'b0;
    bit           heldValid    = 1'b0;
    logic [J-1:0] heldVal;
    logic [1:0]   heldIdx;

    task automatic clearModel();
        bitQ.delete();
        expQ.delete();
        hdrErrExp    = 1'b0;
        groupDoneExp = 1'b0;
        validExp     = 1'b0;
        heldValid    = 1'b0;
    endtask

    // Behavioural encoder: turns a width, mode and four values into the
    // coded bit sequence plus the samples the decoder must produce.
    task automatic encodeGroup(input int w, input bit tc,
                               input int v0, input int v1, input int v2, input int v3);
        int          vals[4];
        int          v;
        int          m;
        logic [1:0]  firstEcg;
        bitItem_t    it;
        sampleItem_t ex;
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        firstEcg = tc ? 2'd3 : 2'($urandom_range(0, 2));
        for (int i = 3; i >= 0; i--) begin
            it.b          = w[i];
            it.ecg        = (i == 3) ? firstEcg : 2'($urandom_range(0, 3));
            it.illegalEnd = (i == 0) && (w > J);
            it.validNext  = (i == 0) && (w == 0);
            bitQ.push_back(it);
        end
        if (w <= J) begin
            for (int s = 0; s < 4; s++) begin
                v = (w == 0) ? 0 : vals[s];
                if (w > 0) begin
                    m = (v < 0) ? -v : v;
                    it.illegalEnd = 1'b0;
                    if (!tc) begin
                        it.b         = (v < 0);
                        it.ecg       = 2'($urandom_range(0, 3));
                        it.validNext = 1'b0;
                        bitQ.push_back(it);
                    end
                    for (int k = w - 1; k >= 0; k--) begin
                        it.b         = tc ? v[k] : m[k];
                        it.ecg       = 2'($urandom_range(0, 3));
                        it.validNext = (k == 0);
                        bitQ.push_back(it);
                    end
                end
                ex.val  = J'(v);
                ex.idx  = 2'(s);
                ex.last = (s == 3);
                expQ.push_back(ex);
            end
        end
    endtask

    task automatic randGroup();
        int r;
        int w;
        bit tc;
        int v[4];
        r  = int'($urandom_range(0, 19));
        tc = 1'($urandom_range(0, 1));
        if (r == 0)      w = int'($urandom_range(11, 15));
        else if (r == 1) w = 0;
        else             w = int'($urandom_range(1, J));
        for (int s = 0; s < 4; s++) begin
            if (w == 0 || w > J) begin
                v[s] = 0;
            end else if (tc || w == J) begin
                v[s] = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
            end else begin
                v[s] = int'($urandom_range(0, (1 << w) - 1));
                if ($urandom_range(0, 1) == 1) v[s] = -v[s];
            end
        end
        encodeGroup(w, tc, v[0], v[1], v[2], v[3]);
    endtask

    // Called at the falling edge: checks what is due this cycle and records
    // what the coming rising edge will transfer.
    task automatic monitorCycle();
        bitItem_t    it;
        sampleItem_t ex;
        nCompared++;
        if (hdr_err !== hdrErrExp) begin
            nMismatched++;
            $display("[TB] FAIL hdr_err: got %b expected %b at %0t", hdr_err, hdrErrExp, $time);
        end
        nCompared++;
        if (group_done !== groupDoneExp) begin
            nMismatched++;
            $display("[TB] FAIL group_done: got %b expected %b at %0t", group_done, groupDoneExp, $time);
        end
        nCompared++;
        if ((bit_ready && sample_valid) !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL ready_exclusive: bit_ready=%b sample_valid=%b expected not both at %0t",
                     bit_ready, sample_valid, $time);
        end
        if (validExp) begin
            nCompared++;
            if (sample_valid !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL latency: sample_valid=%b expected 1 at %0t", sample_valid, $time);
            end
        end
        if (heldValid) begin
            nCompared++;
            if (sample_valid !== 1'b1 || sample_out !== heldVal || sample_idx !== heldIdx) begin
                nMismatched++;
                $display("[TB] FAIL hold: got v=%b out=%h idx=%0d expected v=1 out=%h idx=%0d at %0t",
                         sample_valid, sample_out, sample_idx, heldVal, heldIdx, $time);
            end
        end
        hdrErrExp    = 1'b0;
        groupDoneExp = 1'b0;
        validExp     = 1'b0;
        heldValid    = 1'b0;
        if (bit_valid && bit_ready && bitQ.size() > 0) begin
            it        = bitQ.pop_front();
            bitsTaken++;
            hdrErrExp = it.illegalEnd;
            validExp  = it.validNext;
        end
        if (sample_valid === 1'b1) begin
            if (sample_ready) begin
                nCompared++;
                if (expQ.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL unexpected_sample: got out=%h idx=%0d expected none at %0t",
                             sample_out, sample_idx, $time);
                end else begin
                    ex = expQ.pop_front();
                    if (sample_out !== ex.val || sample_idx !== ex.idx) begin
                        nMismatched++;
                        $display("[TB] FAIL sample: got out=%h idx=%0d expected out=%h idx=%0d at %0t",
                                 sample_out, sample_idx, ex.val, ex.idx, $time);
                    end
                    groupDoneExp = ex.last;
                    if (ex.last) doneCount++;
                end
            end else begin
                heldValid = 1'b1;
                heldVal   = sample_out;
                heldIdx   = sample_idx;
            end
        end
    endtask

    // Streams the queued bits; gapPct<0 toggles bit_valid every other cycle.
    task automatic runStream(input int gapPct, input int bpPct, input bit stall5,
                             input int stopAfterBits, input int maxCycles);
        int cyc       = 0;
        int stallCnt  = 0;
        int startBits = bitsTaken;
        while ((bitQ.size() > 0 || expQ.size() > 0) &&
               (bitsTaken - startBits) < stopAfterBits && cyc < maxCycles) begin
            if (bitQ.size() > 0) begin
                bit_in = bitQ[0].b;
                ecgidx = bitQ[0].ecg;
                if (gapPct < 0) bit_valid = cyc[0];
                else            bit_valid = (int'($urandom_range(0, 99)) >= gapPct);
            end else begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom_range(0, 1));
                ecgidx    = 2'($urandom_range(0, 3));
            end
            if (stall5 && sample_valid && sample_idx == 2'd1 && stallCnt < 5) begin
                sample_ready = 1'b0;
                stallCnt++;
            end else begin
                if (!(sample_valid && sample_idx == 2'd1)) stallCnt = 0;
                sample_ready = (int'($urandom_range(0, 99)) >= bpPct);
            end
            @(negedge clk);
            monitorCycle();
            @(posedge clk);
            #1;
            cyc++;
        end
        bit_valid    = 1'b0;
        sample_ready = 1'b0;
        @(negedge clk);
        monitorCycle();
        @(posedge clk);
        #1;
        nCompared++;
        if (cyc >= maxCycles) begin
            nMismatched++;
            $display("[TB] FAIL timeout: %0d bits and %0d samples left after %0d cycles, expected 0",
                     bitQ.size(), expQ.size(), cyc);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        nCompared++;
        if (sample_valid !== 1'b0 || sample_out !== '0 || sample_idx !== 2'd0 ||
            hdr_err !== 1'b0 || group_done !== 1'b0 || bit_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL %s: got v=%b out=%h idx=%0d err=%b done=%b rdy=%b expected v=0 out=0 idx=0 err=0 done=0 rdy=1",
                     tag, sample_valid, sample_out, sample_idx, hdr_err, group_done, bit_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; ecgidx = 2'd0; sample_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkIdleOutputs("reset_state");
        @(posedge clk);
        #1;
    endtask

    task automatic test_sm_basic();
        int b0;
        int d0;
        b0 = bitsTaken; d0 = doneCount;
        encodeGroup(3, 1'b0, 5, -3, 0, 7);
        runStream(0, 0, 1'b0, 100000, 500);
        nCompared++;
        if (bitsTaken - b0 != 20 || doneCount - d0 != 1) begin
            nMismatched++;
            $display("[TB] FAIL sm_counts: got bits=%0d groups=%0d expected bits=20 groups=1",
                     bitsTaken - b0, doneCount - d0);
        end
    endtask

    task automatic test_tc_basic();
        encodeGroup(3, 1'b1, -4, 3, -1, 0);
        encodeGroup(1, 1'b1, -1, 0, -1, 0);
        runStream(0, 0, 1'b0, 100000, 500);
    endtask

    task automatic test_zero_group();
        encodeGroup(0, 1'b0, 0, 0, 0, 0);
        encodeGroup(0, 1'b1, 0, 0, 0, 0);
        encodeGroup(4, 1'b0, -9, 15, 1, -15);
        runStream(0, 30, 1'b0, 100000, 1000);
    endtask

    task automatic test_illegal_header();
        int d0;
        d0 = doneCount;
        encodeGroup(15, 1'b0, 0, 0, 0, 0);
        encodeGroup(11, 1'b1, 0, 0, 0, 0);
        encodeGroup(2, 1'b0, 3, -3, 1, -2);
        runStream(0, 0, 1'b0, 100000, 500);
        nCompared++;
        if (doneCount - d0 != 1) begin
            nMismatched++;
            $display("[TB] FAIL illegal_groups: got %0d groups expected 1", doneCount - d0);
        end
    endtask

    task automatic test_backpressure();
        encodeGroup(5, 1'b0, -31, 17, 0, 30);
        encodeGroup(6, 1'b1, -32, 31, -7, 8);
        runStream(0, 0, 1'b1, 100000, 1000);
    endtask

    task automatic test_bit_gaps();
        encodeGroup(3, 1'b0, 5, -3, 0, 7);
        runStream(-1, 0, 1'b0, 100000, 1000);
    endtask

    task automatic test_reset_mid_group();
        encodeGroup(3, 1'b0, 5, -3, 6, 7);
        runStream(0, 0, 1'b0, 15, 500);
        rst = 1'b1; bit_valid = 1'b0; sample_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearModel();
        @(negedge clk);
        checkIdleOutputs("reset_mid_group");
        @(posedge clk);
        #1;
        encodeGroup(10, 1'b0, -512, 511, -1, 0);
        runStream(0, 0, 1'b0, 100000, 500);
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 10; g++) randGroup();
        runStream(0, 0, 1'b0, 100000, 5000);
    endtask

    task automatic test_random();
        for (int g = 0; g < 40; g++) randGroup();
        runStream(30, 30, 1'b0, 100000, 20000);
    endtask

    // Test sequence.
    initial begin
        clearModel();
        test_reset();
        test_sm_basic();
        test_tc_basic();
        test_zero_group();
        test_illegal_header();
        test_backpressure();
        test_bit_gaps();
        test_reset_mid_group();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
